// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding, field widths and config record for the PLL reconfiguration controller.
package pll_ctrl_pkg;

    localparam int DIV_W = 6;
    localparam int DA_W  = 4;

    typedef enum logic [2:0] {
        RST_ASSERT   = 3'd0,
        WAIT_LOCK    = 3'd1,
        STABLE_CHECK = 3'd2,
        RUN          = 3'd3,
        FAIL         = 3'd4
    } pll_state_e;

    typedef struct packed {
        logic [DIV_W-1:0] idsel;
        logic [DIV_W-1:0] fbdsel;
        logic [DIV_W-1:0] odsel;
        logic [DA_W-1:0]  psda;
        logic [DA_W-1:0]  dutyda;
    } pll_cfg_t;

    // Counter width for a terminal count of n; never zero bits wide.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK output into the controller clock domain.
// Latency: two clkin edges; no backpressure.
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL bring-up / reconfiguration sequencer: reset pulse, lock wait with retries, stability check.
// Latency: new config on the PLL pins one cycle after transfer; cfg_ready only in RUN/FAIL.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int               RESET_CYCLES       = 16,
    parameter int               LOCK_STABLE_CYCLES = 1024,
    parameter int               LOCK_TIMEOUT       = 65535,
    parameter int               MAX_RETRY          = 3,
    parameter logic [DIV_W-1:0] DEF_IDSEL          = 6'd0,
    parameter logic [DIV_W-1:0] DEF_FBDSEL         = 6'd0,
    parameter logic [DIV_W-1:0] DEF_ODSEL          = 6'd0,
    parameter logic [DA_W-1:0]  DEF_PSDA           = 4'd0,
    parameter logic [DA_W-1:0]  DEF_DUTYDA         = 4'b1000
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_idsel,
    input  logic [DIV_W-1:0] cfg_fbdsel,
    input  logic [DIV_W-1:0] cfg_odsel,
    input  logic [DA_W-1:0]  cfg_psda,
    input  logic [DA_W-1:0]  cfg_dutyda,
    input  logic             err_clr,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             pll_reset_p,
    output logic [DIV_W-1:0] pll_idsel,
    output logic [DIV_W-1:0] pll_fbdsel,
    output logic [DIV_W-1:0] pll_odsel,
    output logic [DA_W-1:0]  pll_psda,
    output logic [DA_W-1:0]  pll_dutyda,
    output logic             clk_ok,
    output logic             busy,
    output logic             lock_lost,
    output logic             err
);

    localparam int RC_W = cnt_w(RESET_CYCLES);
    localparam int ST_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int TO_W = cnt_w(LOCK_TIMEOUT);
    localparam int RT_W = cnt_w(MAX_RETRY + 1);

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts as stable cycle one.
    localparam logic [ST_W-1:0] ST_LAST = ST_W'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    localparam pll_cfg_t DEF_CFG = {DEF_IDSEL, DEF_FBDSEL, DEF_ODSEL, DEF_PSDA, DEF_DUTYDA};

    pll_state_e      state_q, state_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [ST_W-1:0] stab_cnt_q, stab_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [RT_W-1:0] retry_cnt_q, retry_cnt_d;
    pll_cfg_t        cfg_q, cfg_d;
    logic            lost_q, lost_d;

    logic     lk;
    logic     xfer;
    logic     restart;
    pll_cfg_t cfg_in;

    lock_sync u_lock_sync (
        .clk      (clkin),
        .rst      (reset),
        .async_in (pll_lock),
        .sync_out (lk)
    );

    assign cfg_in = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
    assign xfer   = cfg_valid && cfg_ready;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stab_cnt_d  = stab_cnt_q;
        to_cnt_d    = to_cnt_q;
        retry_cnt_d = retry_cnt_q;
        cfg_d       = cfg_q;
        lost_d      = 1'b0;
        restart     = 1'b0;

        case (state_q)
            RST_ASSERT: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d  = WAIT_LOCK;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    stab_cnt_d = '0;
                    if (LOCK_STABLE_CYCLES <= 1) begin
                        state_d     = RUN;
                        retry_cnt_d = '0;
                    end else begin
                        state_d = STABLE_CHECK;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    if (retry_cnt_q < RT_MAX) begin
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        restart     = 1'b1;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            STABLE_CHECK: begin
                if (!lk) begin
                    state_d  = WAIT_LOCK;
                    to_cnt_d = '0;
                end else if (stab_cnt_q == ST_LAST) begin
                    state_d     = RUN;
                    retry_cnt_d = '0;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    lost_d      = 1'b1;
                    restart     = 1'b1;
                    retry_cnt_d = '0;
                end
            end
            FAIL: begin
                if (err_clr) begin
                    restart     = 1'b1;
                    retry_cnt_d = '0;
                end
            end
            default: restart = 1'b1;
        endcase

        // A config transfer overrides lock loss and error clear in the same cycle.
        if (xfer) begin
            cfg_d       = cfg_in;
            restart     = 1'b1;
            retry_cnt_d = '0;
            lost_d      = 1'b0;
        end

        if (restart) begin
            state_d   = RST_ASSERT;
            rst_cnt_d = '0;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= RST_ASSERT;
            rst_cnt_q   <= '0;
            stab_cnt_q  <= '0;
            to_cnt_q    <= '0;
            retry_cnt_q <= '0;
            cfg_q       <= DEF_CFG;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stab_cnt_q  <= stab_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            cfg_q       <= cfg_d;
            lost_q      <= lost_d;
        end
    end

    assign pll_reset   = (state_q == RST_ASSERT) || (state_q == FAIL);
    assign pll_reset_p = pll_reset;
    assign busy        = (state_q == RST_ASSERT) || (state_q == WAIT_LOCK) || (state_q == STABLE_CHECK);
    assign clk_ok      = (state_q == RUN);
    assign cfg_ready   = (state_q == RUN) || (state_q == FAIL);
    assign err         = (state_q == FAIL);
    assign lock_lost   = lost_q;

    assign pll_idsel  = cfg_q.idsel;
    assign pll_fbdsel = cfg_q.fbdsel;
    assign pll_odsel  = cfg_q.odsel;
    assign pll_psda   = cfg_q.psda;
    assign pll_dutyda = cfg_q.dutyda;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: directed bring-up/reconfig/timeout/glitch/reset scenarios,
// then random traffic, all compared every cycle against a behavioural model.
module tb_pll_reconfig_ctrl;
    import pll_ctrl_pkg::*;

    localparam int RC  = 4;
    localparam int LSC = 8;
    localparam int LT  = 32;
    localparam int MR  = 2;

    logic             clkin = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
    logic [DA_W-1:0]  cfg_psda = '0, cfg_dutyda = '0;
    logic             err_clr = 1'b0;
    logic             pll_lock = 1'b0;
    logic             pll_reset, pll_reset_p;
    logic [DIV_W-1:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic [DA_W-1:0]  pll_psda, pll_dutyda;
    logic             clk_ok, busy, lock_lost, err;

    always #5 clkin = ~clkin;

    pll_reconfig_ctrl #(
        .RESET_CYCLES       (RC),
        .LOCK_STABLE_CYCLES (LSC),
        .LOCK_TIMEOUT       (LT),
        .MAX_RETRY          (MR)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idsel   (cfg_idsel),
        .cfg_fbdsel  (cfg_fbdsel),
        .cfg_odsel   (cfg_odsel),
        .cfg_psda    (cfg_psda),
        .cfg_dutyda  (cfg_dutyda),
        .err_clr     (err_clr),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_reset_p (pll_reset_p),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .clk_ok      (clk_ok),
        .busy        (busy),
        .lock_lost   (lock_lost),
        .err         (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: reset cycles still owed, cycles spent waiting, current lock streak.
    int       m_rst_left, m_waited, m_streak, m_retries;
    bit       m_ok, m_failed, m_lost;
    bit       m_h0, m_h1;
    pll_cfg_t m_cfg;

    function automatic void m_start();
        m_rst_left = RC;
        m_failed   = 1'b0;
        m_ok       = 1'b0;
        m_streak   = 0;
        m_waited   = 0;
    endfunction

    function automatic void m_init();
        m_start();
        m_retries = 0;
        m_lost    = 1'b0;
        m_h0      = 1'b0;
        m_h1      = 1'b0;
        m_cfg     = {6'd0, 6'd0, 6'd0, 4'd0, 4'b1000};
    endfunction

    function automatic void m_step();
        bit lk;
        bit xfer;
        lk     = m_h1;
        xfer   = cfg_valid && (m_ok || m_failed);
        m_lost = 1'b0;
        if (xfer) begin
            m_cfg     = {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda};
            m_retries = 0;
            m_start();
        end else if (m_failed) begin
            if (err_clr) begin
                m_retries = 0;
                m_start();
            end
        end else if (m_ok) begin
            if (!lk) begin
                m_lost    = 1'b1;
                m_retries = 0;
                m_start();
            end
        end else if (m_rst_left > 0) begin
            m_rst_left--;
        end else if (lk) begin
            m_streak++;
            if (m_streak == LSC) begin
                m_ok      = 1'b1;
                m_retries = 0;
            end
        end else if (m_streak > 0) begin
            m_streak = 0;
            m_waited = 0;
        end else begin
            m_waited++;
            if (m_waited == LT) begin
                if (m_retries < MR) begin
                    m_retries++;
                    m_start();
                end else begin
                    m_failed = 1'b1;
                end
            end
        end
        m_h1 = m_h0;
        m_h0 = pll_lock;
    endfunction

    always @(posedge clkin or posedge reset) begin
        if (reset) m_init();
        else       m_step();
    end

    always @(negedge clkin) begin
        bit prst;
        prst = m_failed || (m_rst_left > 0);
        chk_eq("ctrl", {pll_reset, pll_reset_p, clk_ok, busy, cfg_ready, lock_lost, err},
               {prst, prst, m_ok, !m_failed && !m_ok, m_ok || m_failed, m_lost, m_failed});
        chk_eq("cfg", {pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda}, m_cfg);
    end

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    initial begin
        int   n, rises, highs, lost_cnt;
        logic prev;
        m_init();
        repeat (3) step();
        chk_eq("rst_pll_reset", pll_reset, 1);
        chk_eq("rst_dutyda", pll_dutyda, 4'b1000);
        chk_eq("rst_busy_ready", {busy, cfg_ready, clk_ok, err}, 4'b1000);

        // Power-up with default config, lock arriving 10 cycles after release
        reset = 1'b0;
        n = 32'(pll_reset);
        repeat (10) begin step(); n += 32'(pll_reset); end
        chk_eq("pwrup_reset_len", n, RC);
        pll_lock = 1'b1;
        n = 0;
        while (!clk_ok && n < 200) begin step(); n++; end
        chk_eq("pwrup_lock_to_ok", n, 2 + LSC);
        chk_eq("pwrup_dutyda", pll_dutyda, 4'b1000);

        // Reconfiguration from RUN
        {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda} = {6'd3, 6'd9, 6'd8, 4'd5, 4'd6};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk_eq("reconf_outs", {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, clk_ok, cfg_ready},
               {1'b1, 6'd3, 6'd9, 6'd8, 1'b0, 1'b0});
        n = 0;
        while (!clk_ok && n < 200) begin step(); n++; end
        chk_eq("reconf_relock", clk_ok, 1);

        // Lock loss in RUN, then permanent loss: one lost pulse, 1+MR reset pulses, FAIL
        pll_lock = 1'b0;
        prev = pll_reset; rises = 0; highs = 0; lost_cnt = 0; n = 0;
        while (!err && n < 500) begin
            step(); n++;
            if (pll_reset && !prev && !err) rises++;
            if (pll_reset && !err) highs++;
            lost_cnt += 32'(lock_lost);
            prev = pll_reset;
        end
        chk_eq("loss_pulse_count", lost_cnt, 1);
        chk_eq("timeout_pulses", rises, 1 + MR);
        chk_eq("timeout_reset_cycles", highs, (1 + MR) * RC);
        chk_eq("fail_state", {err, pll_reset, busy, cfg_ready, pll_idsel}, {4'b1101, 6'd3});
        repeat (5) step();
        chk_eq("fail_hold_reset", {pll_reset, err}, 2'b11);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_eq("errclr_restart", {err, pll_reset, busy}, 3'b011);

        // One-cycle lock glitch at stable count 5 forces a full recount
        n = 0;
        while (pll_reset && n < 100) begin step(); n++; end
        chk_eq("glitch_wait_entry", pll_reset, 0);
        pll_lock = 1'b1; lost_cnt = 0; n = 0;
        repeat (6) begin step(); n++; lost_cnt += 32'(lock_lost); end
        pll_lock = 1'b0;
        step(); n++;
        pll_lock = 1'b1;
        while (!clk_ok && n < 200) begin step(); n++; lost_cnt += 32'(lock_lost); end
        // Lock resampled after the glitch is seen 2 cycles later, then 8 clean cycles
        chk_eq("glitch_recount", n, 7 + 2 + LSC);
        chk_eq("glitch_no_lost", lost_cnt, 0);

        // Lock loss coinciding with a transfer: new config, no lost pulse
        pll_lock = 1'b0;
        step(); step();
        {cfg_idsel, cfg_fbdsel, cfg_odsel, cfg_psda, cfg_dutyda} = {6'd21, 6'd33, 6'd2, 4'd15, 4'd3};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        chk_eq("coinc_cfg", {pll_reset, lock_lost, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda},
               {1'b1, 1'b0, 6'd21, 6'd33, 6'd2, 4'd15, 4'd3});
        lost_cnt = 0;
        repeat (4) begin step(); lost_cnt += 32'(lock_lost); end
        chk_eq("coinc_no_lost", lost_cnt, 0);

        // Asynchronous reset while waiting for lock
        n = 0;
        while (pll_reset && n < 100) begin step(); n++; end
        chk_eq("async_wait_entry", {pll_reset, busy}, 2'b01);
        reset = 1'b1;
        #1;
        chk_eq("async_rst_outs",
               {pll_reset, pll_reset_p, pll_idsel, pll_fbdsel, pll_odsel, pll_psda, pll_dutyda,
                clk_ok, busy, cfg_ready, lock_lost, err},
               {2'b11, 6'd0, 6'd0, 6'd0, 4'd0, 4'b1000, 5'b01000});
        step(); step();
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            if ($urandom_range(0, 59) == 0) pll_lock = ~pll_lock;
            cfg_valid  = ($urandom_range(0, 24) == 0);
            cfg_idsel  = DIV_W'($urandom);
            cfg_fbdsel = DIV_W'($urandom);
            cfg_odsel  = DIV_W'($urandom);
            cfg_psda   = DA_W'($urandom);
            cfg_dutyda = DA_W'($urandom);
            err_clr    = ($urandom_range(0, 19) == 0);
            reset      = ($urandom_range(0, 799) == 0);
        end
        reset = 1'b0; cfg_valid = 1'b0; err_clr = 1'b0;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
